// File: rtl/minesweeper_pkg.sv
// Shared constants, state encoding and LFSR step for the mine placement datapath.
package minesweeper_pkg;

  localparam int BOARD_CELLS = 25;
  localparam int CELL_W      = 5;
  localparam int LFSR_W      = 8;

  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } place_state_e;

  // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mine_lfsr.sv
// Free-running 8-bit LFSR with seed load on restart and a guard against the all-zero lock-up state.
module mine_lfsr
  import minesweeper_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clka,
  input  logic              restart,
  output logic [LFSR_W-1:0] lfsr
);

  // A zero seed would freeze the register, so it is replaced by 1.
  localparam logic [LFSR_W-1:0] RESET_VAL = (SEED == '0) ? 8'h01 : SEED;

  logic [LFSR_W-1:0] next_val;

  // Next value, forced away from zero should the register ever be upset into it.
  always_comb begin
    next_val = lfsr_step(lfsr);
    if (next_val == '0) next_val = 8'h01;
  end

  // Advance every cycle in every state.
  // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) lfsr <= RESET_VAL;
    else         lfsr <= next_val;
  end

endmodule

// File: rtl/mine_placer.sv
// Mine placement responder: on start, clears the bitmap and draws distinct in-range cells from the LFSR.
// Optional feature: define MINE_PLACER_SAFE_CELL_EN to add a safe_cell input that is never mined.
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter int               ROWS      = 5,
  parameter int               COLS      = 5,
  parameter int               NUM_MINES = 5,
  parameter logic [LFSR_W-1:0] SEED     = 8'hA5
) (
  input  logic                 clka,
  input  logic                 restart,
  input  logic                 start,
`ifdef MINE_PLACER_SAFE_CELL_EN
  input  logic [CELL_W-1:0]    safe_cell,
`endif
  output logic                 place_done,
  output logic                 busy,
  output logic [ROWS*COLS-1:0] mine_map,
  output logic [4:0]           mine_count
);

  localparam int         CELLS      = ROWS * COLS;
  localparam logic [4:0] LAST_COUNT = 5'(NUM_MINES - 1);

  place_state_e      state;
  logic [LFSR_W-1:0] lfsr;
  logic [CELL_W-1:0] cand;
  logic              in_range;
  logic              is_safe;
  logic              accept;
  logic              take_start;

  mine_lfsr #(.SEED(SEED)) u_lfsr (
    .clka    (clka),
    .restart (restart),
    .lfsr    (lfsr)
  );

  assign cand       = lfsr[CELL_W-1:0];
  assign in_range   = int'(cand) < CELLS;
  assign take_start = start && ((state == IDLE) || (state == DONE));

`ifdef MINE_PLACER_SAFE_CELL_EN
  logic [CELL_W-1:0] safe_q;

  // Capture the player's first cell when a placement request is accepted.
  always_ff @(posedge clka or posedge restart) begin
    if (restart)         safe_q <= '0;
    else if (take_start) safe_q <= safe_cell;
  end

  assign is_safe = (cand == safe_q);
`else
  assign is_safe = 1'b0;
`endif

  // A candidate is taken only if it lies on the board, is not yet a mine and is not the safe cell.
  assign accept = in_range && !mine_map[cand] && !is_safe;

  // Placement FSM with registered handshake outputs, bitmap and counter.
  // NOTE: the bitmap is a plain register vector, so it is reset like any other state bit.
  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state      <= IDLE;
      mine_map   <= '0;
      mine_count <= '0;
      place_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take_start) state <= CLEAR;
        CLEAR: begin
          mine_map   <= '0;
          mine_count <= '0;
          place_done <= 1'b0;
          busy       <= 1'b1;
          state      <= DRAW;
        end
        DRAW: begin
          if (accept) begin
            mine_map[cand] <= 1'b1;
            mine_count     <= mine_count + 5'd1;
            if (mine_count == LAST_COUNT) begin
              busy       <= 1'b0;
              place_done <= 1'b1;
              state      <= DONE;
            end
          end
        end
        DONE: if (take_start) state <= CLEAR;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Directed self-checking bench for mine_placer with an independent LFSR reference model.
module tb_mine_placer;
  import minesweeper_pkg::*;

  logic        clka = 1'b0;
  logic        restart = 1'b1;
  logic        start = 1'b0;
  logic        place_done, busy;
  logic [24:0] mine_map;
  logic [4:0]  mine_count;

  int errors = 0;
  int checks = 0;

  always #5 clka = ~clka;

`ifdef MINE_PLACER_SAFE_CELL_EN
  localparam int SAFE = 12;
  logic [4:0]  safe_cell = 5'd12;
  logic        start_b = 1'b0;
  logic        place_done_b, busy_b;
  logic [24:0] mine_map_b;
  logic [4:0]  mine_count_b;

  mine_placer #(.NUM_MINES(24)) u_big (
    .clka(clka), .restart(restart), .start(start_b), .safe_cell(safe_cell),
    .place_done(place_done_b), .busy(busy_b), .mine_map(mine_map_b), .mine_count(mine_count_b)
  );
`else
  localparam int SAFE = -1;
`endif

  mine_placer dut (
    .clka(clka), .restart(restart), .start(start),
`ifdef MINE_PLACER_SAFE_CELL_EN
    .safe_cell(safe_cell),
`endif
    .place_done(place_done), .busy(busy), .mine_map(mine_map), .mine_count(mine_count)
  );

  // Reference LFSR, written directly from the polynomial.
  logic [7:0] m_lfsr;
  always @(posedge clka or posedge restart) begin
    if (restart) m_lfsr <= 8'hA5;
    else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Replays the draws from the first evaluated LFSR value; returns the map and DRAW cycle count.
  task automatic model(input logic [7:0] l0, input int nm, input int safe,
                       output logic [24:0] map, output int cyc);
    logic [7:0] l;
    int n, c;
    l = l0; n = 0; map = '0; cyc = 0;
    while (n < nm && cyc < 2000) begin
      cyc++;
      c = int'(l[4:0]);
      if (c < 25 && !map[c] && c != safe) begin
        map[c] = 1'b1;
        n++;
      end
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  // One placement: start strobe, handshake checks, optional ignored start or restart, result checks.
  task automatic run(input string tag, input int pulse_at, input int restart_at,
                     input logic [24:0] prev_map, output logic [24:0] got);
    logic        was_done, mono;
    logic [24:0] exp_map, stable;
    logic [4:0]  prev_cnt;
    int          exp_cyc, waited;
    was_done = place_done;
    start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    check({tag, "/pd_after_start"}, place_done, was_done);
    check({tag, "/busy_after_start"}, busy, 1'b0);
    @(posedge clka); #1;
    check({tag, "/busy_clear"}, busy, 1'b1);
    check({tag, "/pd_clear"}, place_done, 1'b0);
    check({tag, "/map_clear"}, mine_map, 25'h0);
    check({tag, "/cnt_clear"}, mine_count, 5'd0);
    model(m_lfsr, 5, SAFE, exp_map, exp_cyc);
    waited = 0; mono = 1'b1; prev_cnt = '0;
    while (!place_done && waited < 1300) begin
      if (waited == pulse_at) start = 1'b1;
      @(posedge clka); #1;
      start = 1'b0;
      waited++;
      if (mine_count < prev_cnt) mono = 1'b0;
      prev_cnt = mine_count;
      if (restart_at >= 0 && int'(mine_count) == restart_at) begin
        restart = 1'b1;
        #1;
        check({tag, "/rst_map"}, mine_map, 25'h0);
        check({tag, "/rst_cnt"}, mine_count, 5'd0);
        check({tag, "/rst_state"}, 32'(dut.state), 32'(IDLE));
        check({tag, "/rst_busy"}, busy, 1'b0);
        @(posedge clka); #1;
        restart = 1'b0;
        got = '0;
        return;
      end
    end
    check({tag, "/done"}, place_done, 1'b1);
    check({tag, "/latency"}, waited, exp_cyc);
    check({tag, "/map"}, mine_map, exp_map);
    check({tag, "/cnt"}, mine_count, 5'd5);
    check({tag, "/popcount"}, $countones(mine_map), 5);
    check({tag, "/monotonic"}, mono, 1'b1);
    check({tag, "/differs"}, mine_map != prev_map, exp_map != prev_map);
    stable = 25'h0;
    repeat (3) begin
      @(posedge clka); #1;
      if (!place_done || busy || mine_map != exp_map) stable = 25'h1;
    end
    check({tag, "/held"}, stable, 25'h0);
    got = mine_map;
  endtask

  initial begin
    logic [24:0] m1, m2, m3, m4, m5;
    logic        quiet;
    int          waited;

    repeat (3) @(posedge clka);
    #1;
    check("rst/pd", place_done, 1'b0);
    check("rst/busy", busy, 1'b0);
    check("rst/map", mine_map, 25'h0);
    check("rst/cnt", mine_count, 5'd0);
    check("rst/lfsr", dut.lfsr, 8'hA5);
    restart = 1'b0;
    @(posedge clka); #1;
    check("lfsr/step1", dut.lfsr, 8'h4A);
    quiet = 1'b1;
    repeat (9) begin
      @(posedge clka); #1;
      if (place_done || busy) quiet = 1'b0;
    end
    check("idle/no_done", quiet, 1'b1);

    run("basic", -1, -1, 25'h0, m1);
    run("ignore", 4, -1, m1, m2);
    run("restart", -1, 2, m2, m3);
    run("after_rst", -1, -1, 25'h0, m4);
    repeat (3) @(posedge clka);
    #1;
    run("replace", -1, -1, m4, m5);

`ifdef MINE_PLACER_SAFE_CELL_EN
    start_b = 1'b1;
    @(posedge clka); #1;
    start_b = 1'b0;
    waited = 0;
    while (!place_done_b && waited < 6200) begin
      @(posedge clka); #1;
      waited++;
    end
    check("safe24/done", place_done_b, 1'b1);
    check("safe24/map", mine_map_b, 25'h1FFEFFF);
    check("safe24/cnt", mine_count_b, 5'd24);
    for (int i = 0; i < 100; i++) begin
      repeat ($urandom_range(0, 7)) @(posedge clka);
      #1;
      run("safe5", -1, -1, m5, m5);
      check("safe5/bit12", m5[12], 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
